// File: rtl/str_rev_pkg.sv
// Shared types and defaults for the byte-serial string reverser.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package str_rev_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam int DATA_W_DEF  = 8;
   localparam int MAX_LEN_DEF = 16;

   // Counter must hold 0..MAX_LEN inclusive.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   localparam int LEN_W_DEF = len_w(MAX_LEN_DEF);

endpackage

// File: rtl/str_lifo.sv
// Register stack of MAX_LEN characters with push/pop and occupancy count.
// Latency: push/pop take effect on the next clock; top_o is combinational from state.
// Backpressure: push ignored when full, pop ignored when empty; push yields to pop.
module str_lifo
   import str_rev_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int CNT_W   = len_w(MAX_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_dat_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] top_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [DATA_W-1:0] mem_q [MAX_LEN];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_m1;
   logic [AW-1:0]     wr_idx, rd_idx;
   logic              push_ok, pop_ok;

   assign full_o  = (cnt_q == CNT_W'(MAX_LEN));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o & ~pop_i;
   assign pop_ok  = pop_i & ~empty_o;
   assign cnt_m1  = cnt_q - CNT_W'(1);
   assign wr_idx  = cnt_q[AW-1:0];
   assign rd_idx  = empty_o ? '0 : cnt_m1[AW-1:0];
   assign top_o   = mem_q[rd_idx];
   assign cnt_o   = cnt_q;

   // Occupancy next-state: saturates at both ends by construction of push_ok/pop_ok.
   always_comb begin
      cnt_d = cnt_q;
      if (push_ok)     cnt_d = cnt_q + CNT_W'(1);
      else if (pop_ok) cnt_d = cnt_m1;
   end

   // Occupancy register; reset discards whatever is stacked.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Storage needs no reset: slots above cnt_q are never read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_idx] <= push_dat_i;
   end

endmodule

// File: rtl/string_stream_reverser.sv
// Byte-serial string reverser: fills a LIFO, then drains it in reverse order.
// Latency: first reversed byte valid the cycle after the terminating input handshake.
// Backpressure: in_ready low while draining; output held stable while out_ready is low.
// Optional: define STR_REV_NULL_TERM_EN to make a 0x00 byte terminate (and not be stored).
module string_stream_reverser
   import str_rev_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              trunc,
   output logic              rev_done
);

   localparam int CNT_W = len_w(MAX_LEN);

   state_t            state_q, state_d;
   logic              trunc_q, trunc_d;
   logic              rev_done_q, rev_done_d;
   logic              push, pop;
   logic              in_hs, out_hs, is_nul;
   logic [DATA_W-1:0] top_dat;
   logic [CNT_W-1:0]  cnt;
   logic              full, empty;

   str_lifo #(
      .DATA_W  (DATA_W),
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) u_lifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (in_data),
      .pop_i      (pop),
      .top_o      (top_dat),
      .cnt_o      (cnt),
      .full_o     (full),
      .empty_o    (empty)
   );

   assign in_hs  = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

`ifdef STR_REV_NULL_TERM_EN
   assign is_nul = (in_data == '0);
`else
   assign is_nul = 1'b0;
`endif

   // State and pulse registers; pulses are registered so they land the cycle after the event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         trunc_q    <= 1'b0;
         rev_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         trunc_q    <= trunc_d;
         rev_done_q <= rev_done_d;
      end
   end

   // Next-state: terminate on last / NUL / reaching capacity, return to FILL after final pop.
   always_comb begin
      state_d    = state_q;
      trunc_d    = 1'b0;
      rev_done_d = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      case (state_q)
         FILL: begin
            if (in_hs) begin
               if (is_nul) begin
                  // NUL is a terminator only; an empty string completes with no output.
                  if (cnt == '0) rev_done_d = 1'b1;
                  else           state_d    = DRAIN;
               end else begin
                  push = 1'b1;
                  if (in_last) begin
                     state_d = DRAIN;
                  end else if (cnt == CNT_W'(MAX_LEN - 1)) begin
                     state_d = DRAIN;
                     trunc_d = 1'b1;
                  end
               end
            end
         end
         DRAIN: begin
            if (out_hs) begin
               pop = 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state_d    = FILL;
                  rev_done_d = 1'b1;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Outputs: output data is forced to zero outside DRAIN so idle/reset value is defined.
   always_comb begin
      in_ready  = (state_q == FILL) & ~full;
      out_valid = (state_q == DRAIN) & ~empty;
      out_data  = out_valid ? top_dat : '0;
      out_last  = out_valid & (cnt == CNT_W'(1));
      trunc     = trunc_q;
      rev_done  = rev_done_q;
   end

endmodule

// File: tb/tb_string_stream_reverser.sv
// Scoreboard bench for string_stream_reverser: queue-based reference model, random backpressure.
// Latency: n/a.
// Backpressure: out_ready driven randomly by the monitor at a programmable percentage.
module tb_string_stream_reverser;

   localparam int DW  = 8;
   localparam int MXL = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          trunc;
   logic          rev_done;

   string_stream_reverser #(.DATA_W(DW), .MAX_LEN(MXL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .trunc     (trunc),
      .rev_done  (rev_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [DW-1:0] cur_q [$];
   logic [DW:0]   exp_q [$];   // {last, data}
   int            exp_trunc = 0, exp_done = 0;
   int            obs_trunc = 0, obs_done = 0;
   int            rdy_pct = 100;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void flush_string();
      for (int i = cur_q.size() - 1; i >= 0; i--)
         exp_q.push_back({(i == 0), cur_q[i]});
      exp_done++;
      cur_q.delete();
   endfunction

   // String rules: last or capacity terminates; optionally NUL terminates without being kept.
   function automatic void model_accept(input logic [DW-1:0] d, input logic l);
`ifdef STR_REV_NULL_TERM_EN
      if (d == '0) begin
         if (cur_q.size() == 0) exp_done++;
         else                   flush_string();
         return;
      end
`endif
      cur_q.push_back(d);
      if (l) flush_string();
      else if (cur_q.size() == MXL) begin
         flush_string();
         exp_trunc++;
      end
   endfunction

   // Called at a negedge; returns at the negedge following the handshake with in_valid still high.
   task automatic send_byte(input logic [DW-1:0] d, input logic l);
      int waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready) begin
         @(negedge clk);
         waited++;
         if (waited > 2000) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      model_accept(d, l);
      @(negedge clk);
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_drain(input string name);
      int waited = 0;
      while (exp_q.size() != 0 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      chk({name, "_drain_timeout"}, exp_q.size(), 0);
      repeat (3) @(negedge clk);
      chk({name, "_trunc_cnt"}, obs_trunc, exp_trunc);
      chk({name, "_done_cnt"}, obs_done, exp_done);
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks protocol rules.
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_dat;
   logic          prev_last;
   logic          want_done = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         want_done  = 1'b0;
         out_ready  = 1'b0;
      end else begin
         if (want_done) chk("rev_done_after_last", int'(rev_done), 1);
         want_done = 1'b0;
         if (rev_done) obs_done++;
         if (trunc)    obs_trunc++;
         if (out_valid) chk("no_fill_during_drain", int'(in_ready), 0);
         if (prev_stall) begin
            chk("stall_valid_held", int'(out_valid), 1);
            chk("stall_data_held", int'(out_data), int'(prev_dat));
            chk("stall_last_held", int'(out_last), int'(prev_last));
         end
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", int'(out_data), -1);
            end else begin
               logic [DW:0] e;
               e = exp_q.pop_front();
               chk("out_data", int'(out_data), int'(e[DW-1:0]));
               chk("out_last", int'(out_last), int'(e[DW]));
            end
            if (out_last) want_done = 1'b1;
         end
         prev_stall = out_valid && !out_ready;
         prev_dat   = out_data;
         prev_last  = out_last;
      end
   end

   task automatic check_reset_outputs(input string name);
      chk({name, "_in_ready"},  int'(in_ready),  1);
      chk({name, "_out_valid"}, int'(out_valid), 0);
      chk({name, "_out_data"},  int'(out_data),  0);
      chk({name, "_out_last"},  int'(out_last),  0);
      chk({name, "_trunc"},     int'(trunc),     0);
      chk({name, "_rev_done"},  int'(rev_done),  0);
   endtask

   initial begin
      logic [DW-1:0] b;
      int len;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // "ABC"
      rdy_pct = 100;
      send_byte(8'h41, 1'b0);
      send_byte(8'h42, 1'b0);
      send_byte(8'h43, 1'b1);
      idle_in();
      wait_drain("abc");
      chk("abc_in_ready_again", int'(in_ready), 1);

      // 16 bytes, in_last on the 16th: exact capacity, no truncation
      for (int i = 0; i < 16; i++) send_byte(DW'(i), (i == 15));
      idle_in();
      wait_drain("full16");

      // 17 bytes without last: first 16 truncated, 17th starts the next string
      for (int i = 0; i < 17; i++) send_byte(DW'(8'h20 + i), 1'b0);
      send_byte(8'h55, 1'b1);
      idle_in();
      wait_drain("over17");

      // "HELLO" under backpressure
      rdy_pct = 40;
      send_byte(8'h48, 1'b0);
      send_byte(8'h45, 1'b0);
      send_byte(8'h4C, 1'b0);
      send_byte(8'h4C, 1'b0);
      send_byte(8'h4F, 1'b1);
      idle_in();
      wait_drain("hello");

      // Reset mid-string discards buffered bytes
      rdy_pct = 100;
      send_byte(8'h31, 1'b0);
      send_byte(8'h32, 1'b0);
      send_byte(8'h33, 1'b0);
      idle_in();
      rst = 1'b1;
      cur_q.delete();
      repeat (2) @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      send_byte(8'h58, 1'b0);
      send_byte(8'h59, 1'b1);
      idle_in();
      wait_drain("xy");

      // Single-character string
      send_byte(8'h7E, 1'b1);
      idle_in();
      wait_drain("single");

`ifdef STR_REV_NULL_TERM_EN
      send_byte(8'h41, 1'b0);
      send_byte(8'h42, 1'b0);
      send_byte(8'h00, 1'b0);
      idle_in();
      wait_drain("nul_ab");
      send_byte(8'h00, 1'b0);
      idle_in();
      wait_drain("nul_empty");
`endif

      // Random strings and random backpressure
      for (int s = 0; s < 25; s++) begin
         rdy_pct = $urandom_range(30, 100);
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            b = DW'($urandom_range(0, 255));
            send_byte(b, (i == len - 1) && ($urandom_range(0, 99) < 80));
            if ($urandom_range(0, 3) == 0) begin
               idle_in();
               @(negedge clk);
            end
         end
      end
      send_byte(8'hA5, 1'b1);
      idle_in();
      wait_drain("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "timeout");
   end

endmodule
